// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state encoding and slice width for the nibble-serial adder
package serial_add_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/add4_slice.sv
// add4_slice: combinational 4-bit adder slice
// ports: a, b (4-bit addends), cin (carry-in) -> sum (4-bit), cout (carry-out)
module add4_slice
  import serial_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  assign {cout, sum} = a + b + {{SLICE_W{1'b0}}, cin};
endmodule

// File: rtl/serial_add16_ctrl.sv
// serial_add16_ctrl: valid/ready adder computing {carry,sum} = a + b + cin one 4-bit slice per cycle
// ports: clk, rst_n (async active-low); in_valid/in_ready + a, b, cin (request);
//        out_valid/out_ready + sum, carry (result); busy (RUN or DONE);
//        ovf (signed overflow) only when SERIAL_ADD_OVF_EN is defined
module serial_add16_ctrl
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   carry,
  output logic                   busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic                   ovf
`endif
);
  localparam int W  = SLICE_W * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t               state, state_n;
  logic   [IW-1:0]      idx;
  logic   [W-1:0]       a_q, b_q;
  logic   [SLICE_W-1:0] sa, sb, ss;
  logic                 sc, last, accept;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign accept    = in_valid && in_ready;
  assign last      = idx == IW'(NIBBLES - 1);
  assign sa        = a_q[idx*SLICE_W +: SLICE_W];
  assign sb        = b_q[idx*SLICE_W +: SLICE_W];
  add4_slice u_slice (.a(sa), .b(sb), .cin(carry), .sum(ss), .cout(sc));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (out_ready ? IDLE : DONE);
  end
  // The carry register doubles as the latched carry-in: it seeds slice 0 and then chains slices.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      idx   <= '0;
      carry <= cin;
    end else if (state == RUN) begin
      sum[idx*SLICE_W +: SLICE_W] <= ss;
      carry <= sc;
      idx   <= idx + IW'(1);
    end
`ifdef SERIAL_ADD_OVF_EN
  // Carry into the MSB is recovered from the top slice's MSB bits: a^b^s.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                   ovf <= 1'b0;
    else if (state == RUN && last) ovf <= sa[SLICE_W-1] ^ sb[SLICE_W-1] ^ ss[SLICE_W-1] ^ sc;
`endif
endmodule

// File: tb/tb_serial_add16_ctrl.sv
// tb_serial_add16_ctrl: directed self-checking bench for serial_add16_ctrl (NIBBLES=4)
module tb_serial_add16_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        carry;
  logic        busy;
`ifdef SERIAL_ADD_OVF_EN
  logic        ovf;
`endif
  int n_cmp = 0;
  int n_err = 0;
  int t0, t1;
  serial_add16_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .busy(busy)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                        input logic [15:0] es, input logic ec, input int hold);
    a = x; b = y; cin = c; in_valid = 1'b1;
    chk("in_ready_idle", {31'b0, in_ready}, 1);
    step();
    in_valid = 1'b0; a = ~x; b = ~y; cin = ~c;
    for (int i = 0; i < 4; i++) begin
      chk("run_no_valid", {31'b0, out_valid}, 0);
      chk("run_busy", {31'b0, busy}, 1);
      step();
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {31'b0, out_valid}, 1);
      chk("hold_in_ready", {31'b0, in_ready}, 0);
      chk("hold_sum", {16'b0, sum}, {16'b0, es});
      step();
    end
    chk("done_valid", {31'b0, out_valid}, 1);
    chk("done_sum", {16'b0, sum}, {16'b0, es});
    chk("done_carry", {31'b0, carry}, {31'b0, ec});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("idle_after_hs", {31'b0, in_ready}, 1);
    chk("idle_valid_low", {31'b0, out_valid}, 0);
    chk("sum_kept", {16'b0, sum}, {16'b0, es});
    chk("carry_kept", {31'b0, carry}, {31'b0, ec});
  endtask
  initial begin
    #3;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_sum", {16'b0, sum}, 0);
    chk("rst_carry", {31'b0, carry}, 0);
    step();
    rst_n = 1'b1;
    step();
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0);
    run_op(16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 0);
    run_op(16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 5);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'b0, in_ready}, 1);
    chk("abort_out_valid", {31'b0, out_valid}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_sum", {16'b0, sum}, 0);
    chk("abort_carry", {31'b0, carry}, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_valid", {31'b0, out_valid}, 0);
      step();
    end
    run_op(16'h0003, 16'h0001, 1'b0, 16'h0004, 1'b0, 0);
    a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    t0 = -1; t1 = -1;
    for (int k = 0; k < 20 && t1 < 0; k++) begin
      if (in_ready) begin
        if (t0 < 0) t0 = k;
        else t1 = k;
      end
      if (out_valid) chk("b2b_first_sum", {16'b0, sum}, 32'h3);
      step();
      if (t0 >= 0) begin a = 16'h0005; b = 16'h0006; end
    end
    in_valid = 1'b0;
    chk("b2b_gap", t1 - t0, 6);
    for (int k = 0; k < 10 && !out_valid; k++) step();
    chk("b2b_second_valid", {31'b0, out_valid}, 1);
    chk("b2b_second_sum", {16'b0, sum}, 32'hB);
    step();
    out_ready = 1'b0;
    chk("b2b_idle", {31'b0, in_ready}, 1);
`ifdef SERIAL_ADD_OVF_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 0);
    chk("ovf_set", {31'b0, ovf}, 1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
    chk("ovf_clear", {31'b0, ovf}, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_add16_ctrl.md
SERIAL_ADD16_CTRL -- requirements
Module: serial_add16_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, requester presents operands.
REQ-005 SHALL have port in_ready, output, 1, controller can accept operands.
REQ-006 SHALL have ports a and b, input, W each, addends.
REQ-007 SHALL have port cin, input, 1, carry-in.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port sum, output, W, registered result.
REQ-011 SHALL have port carry, output, 1, registered carry-out.
REQ-012 SHALL have port busy, output, 1, high in RUN or DONE.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept on in_valid&&in_ready: latch a, b and cin into internal registers, clear the slice index, then go IDLE->RUN.
REQ-016 SHALL in RUN add one 4-bit slice per cycle, LSB slice first, using one shared 4-bit adder fed by the latched carry; write the slice sum into sum[4i+3:4i] and the slice carry-out into the carry register.
REQ-017 SHALL go RUN->DONE on the cycle that processes slice NIBBLES-1; out_valid rises exactly NIBBLES cycles after the accept edge.
REQ-018 SHALL hold sum, carry and out_valid stable in DONE while out_ready=0.
REQ-019 SHALL go DONE->IDLE on out_valid&&out_ready; sum and carry keep their values until the next accept.
REQ-020 SHALL ignore in_valid outside IDLE; a held in_valid is accepted on the first IDLE cycle after the result handshake, so back-to-back throughput is one operation per NIBBLES+2 cycles.
REQ-021 SHALL ignore input operand changes after acceptance.
REQ-022 SHALL give the arithmetic result {carry,sum} = a + b + cin modulo 2^(W+1), with no saturation.

Reset
REQ-023 SHALL on rst_n=0 immediately force state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carry=0, slice index=0, latched operands=0.
REQ-024 SHALL abort any operation in progress when reset is asserted in RUN or DONE; no partial result is delivered.

Configuration
REQ-025 SHALL honour macro SERIAL_ADD_OVF_EN: when defined, add output ovf (1 bit) equal to the carry into the MSB XOR carry-out, registered on the final RUN cycle, valid with out_valid, and reset to 0.
REQ-026 SHALL have no ovf port and no related logic when SERIAL_ADD_OVF_EN is undefined; all other behaviour is identical.

Structure
REQ-027 SHALL place the state enum (IDLE/RUN/DONE) and the constant SLICE_W=4 in shared package serial_add_pkg.
REQ-028 SHALL instantiate exactly one combinational sub-module, add4_slice (4-bit a, b, cin -> 4-bit sum, carry-out), as the shared adder.

Verification
REQ-029 SHALL check: reset, then a=0x1234, b=0x4321, cin=0 accepted -> out_valid after 4 cycles, sum=0x5555, carry=0.
REQ-030 SHALL check: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry=1; also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, carry=1.
REQ-031 SHALL check: out_ready held 0 for 5 cycles with a=0x00F0, b=0x0F10 -> sum=0x1000 held stable, in_ready=0 throughout; release -> IDLE next cycle.
REQ-032 SHALL check: rst_n pulsed low at the second RUN cycle -> outputs immediately at reset values, no out_valid; the next request (0x0003+0x0001) -> 0x0004.
REQ-033 SHALL check: in_valid held high across two requests -> second accepted exactly 6 cycles after the first.
REQ-034 SHALL check, with SERIAL_ADD_OVF_EN defined: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, carry=0; 0xFFFF+0x0001 -> ovf=0.
